// File: rtl/pio_edge_in.sv
// pio_edge_in: Avalon-MM input port with per-bit edge capture (W1C), IRQ mask and IRQ output.
// Define PIO_EDGE_IN_SYNC_EN to insert a 2-flop synchronizer on in_port (S = 2 instead of 0).
module pio_edge_in #(
    parameter int WIDTH     = 1,
    parameter int EDGE_TYPE = 0,
    parameter int IRQ_MODE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] irqMask_q, irqMask_d;
    logic [WIDTH-1:0] edgeCap_q, edgeCap_d;
    logic [WIDTH-1:0] edgeDet;
    logic [WIDTH-1:0] clrMask;
    logic [31:0]      readdata_q, readdata_d;
    logic             wrEn;
    logic             unusedWrite;

`ifdef PIO_EDGE_IN_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    assign dataIn = sync2_q;
`else
    assign dataIn = in_port;
`endif

    assign wrEn        = chipselect & ~write_n;
    // Upper writedata bits are architecturally ignored when WIDTH < 32.
    assign unusedWrite = ^writedata;

    always_comb begin
        edgeDet = '0;
        case (EDGE_TYPE)
            0:       edgeDet = dataIn & ~prev_q;
            1:       edgeDet = ~dataIn & prev_q;
            default: edgeDet = dataIn ^ prev_q;
        endcase
    end

    // A fresh edge wins over a same-cycle write-1-to-clear of that bit.
    always_comb begin
        clrMask   = '0;
        irqMask_d = irqMask_q;
        if (wrEn && (address == 2'd3)) begin
            clrMask = writedata[WIDTH-1:0];
        end
        if (wrEn && (address == 2'd2)) begin
            irqMask_d = writedata[WIDTH-1:0];
        end
        edgeCap_d = (edgeCap_q & ~clrMask) | edgeDet;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = dataIn;
            2'd2:    readdata_d[WIDTH-1:0] = irqMask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgeCap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqMask_q  <= '0;
            edgeCap_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= dataIn;
            irqMask_q  <= irqMask_d;
            edgeCap_q  <= edgeCap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

    // Level mode uses prev_q so irq never depends combinationally on in_port.
    generate
        if (IRQ_MODE == 1) begin : gIrqEdge
            assign irq = |(edgeCap_q & irqMask_q);
        end else begin : gIrqLevel
            assign irq = |(prev_q & irqMask_q);
        end
    endgenerate

endmodule

// File: tb/tb_pio_edge_in.sv
// tb_pio_edge_in: four WIDTH=8 instances (rising/edge-irq, falling, any, rising/level-irq)
// share one bus and input; expected values are queued per step and compared by checkOutput.
module tb_pio_edge_in;

`ifdef PIO_EDGE_IN_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [1:0]   address = 2'd0;
    logic [31:0]  writedata = 32'h0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  rdA, rdF, rdY, rdL;
    logic         irqA, irqF, irqY, irqL;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic [W-1:0] inPort;
        logic         wr;
        logic [1:0]   addr;
        logic [31:0]  wdata;
        logic [31:0]  rA, rF, rY, rL;
        logic [3:0]   irqs;
    } vec_t;

    exp_t sbQ[$];
    vec_t vecs[17];

    always #5 clk = ~clk;

    pio_edge_in #(.WIDTH(W), .EDGE_TYPE(0), .IRQ_MODE(1)) dutA (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdA), .irq(irqA));
    pio_edge_in #(.WIDTH(W), .EDGE_TYPE(1), .IRQ_MODE(1)) dutF (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdF), .irq(irqF));
    pio_edge_in #(.WIDTH(W), .EDGE_TYPE(2), .IRQ_MODE(1)) dutY (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdY), .irq(irqY));
    pio_edge_in #(.WIDTH(W), .EDGE_TYPE(0), .IRQ_MODE(0)) dutL (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rdL), .irq(irqL));

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return rdA;
            1:       return rdF;
            2:       return rdY;
            3:       return rdL;
            4:       return {31'b0, irqA};
            5:       return {31'b0, irqF};
            6:       return {31'b0, irqY};
            default: return {31'b0, irqL};
        endcase
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic busIdle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic expectVal(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sbQ.push_back(e);
    endtask

    task automatic expectAll(input string tag, input logic [31:0] rA, input logic [31:0] rF,
                             input logic [31:0] rY, input logic [31:0] rL, input logic [3:0] irqs);
        expectVal({tag, " rdA"}, 0, rA);
        expectVal({tag, " rdF"}, 1, rF);
        expectVal({tag, " rdY"}, 2, rY);
        expectVal({tag, " rdL"}, 3, rL);
        expectVal({tag, " irqA"}, 4, {31'b0, irqs[3]});
        expectVal({tag, " irqF"}, 5, {31'b0, irqs[2]});
        expectVal({tag, " irqY"}, 6, {31'b0, irqs[1]});
        expectVal({tag, " irqL"}, 7, {31'b0, irqs[0]});
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] act;
        while (sbQ.size() > 0) begin
            e   = sbQ.pop_front();
            act = actual(e.sel);
            checks++;
            if (act === e.exp) begin
                passes++;
            end else begin
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
            end
        end
    endtask

    // Settle input for S+1 edges, do the optional write, then one edge so readdata reflects it.
    task automatic applyStimulus(input vec_t v, input int idx);
        expectAll($sformatf("vec%0d", idx), v.rA, v.rF, v.rY, v.rL, v.irqs);
        in_port = v.inPort;
        address = v.addr;
        busIdle();
        tick(S + 1);
        if (v.wr) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
            writedata  = v.wdata;
        end
        tick(1);
        busIdle();
        tick(1);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        //           in     wr    addr   wdata          rdA    rdF    rdY    rdL    irq{A,F,Y,L}
        vecs[0]  = '{8'h00, 1'b0, 2'd0, 32'h0,         32'h00, 32'h00, 32'h00, 32'h00, 4'b0000};
        vecs[1]  = '{8'h05, 1'b0, 2'd3, 32'h0,         32'h05, 32'h00, 32'h05, 32'h05, 4'b0000};
        vecs[2]  = '{8'h05, 1'b0, 2'd0, 32'h0,         32'h05, 32'h05, 32'h05, 32'h05, 4'b0000};
        vecs[3]  = '{8'h05, 1'b1, 2'd2, 32'h104,       32'h04, 32'h04, 32'h04, 32'h04, 4'b1011};
        vecs[4]  = '{8'h01, 1'b0, 2'd3, 32'h0,         32'h05, 32'h04, 32'h05, 32'h05, 4'b1110};
        vecs[5]  = '{8'h01, 1'b1, 2'd3, 32'h04,        32'h01, 32'h00, 32'h01, 32'h01, 4'b0000};
        vecs[6]  = '{8'h01, 1'b1, 2'd0, 32'hFF,        32'h01, 32'h01, 32'h01, 32'h01, 4'b0000};
        vecs[7]  = '{8'h01, 1'b1, 2'd1, 32'hFF,        32'h00, 32'h00, 32'h00, 32'h00, 4'b0000};
        vecs[8]  = '{8'h01, 1'b1, 2'd3, 32'hFF,        32'h00, 32'h00, 32'h00, 32'h00, 4'b0000};
        vecs[9]  = '{8'h09, 1'b0, 2'd3, 32'h0,         32'h08, 32'h00, 32'h08, 32'h08, 4'b0000};
        vecs[10] = '{8'h09, 1'b1, 2'd2, 32'h08,        32'h08, 32'h08, 32'h08, 32'h08, 4'b1011};
        vecs[11] = '{8'h01, 1'b0, 2'd3, 32'h0,         32'h08, 32'h08, 32'h08, 32'h08, 4'b1110};
        vecs[12] = '{8'h01, 1'b1, 2'd3, 32'hFF,        32'h00, 32'h00, 32'h00, 32'h00, 4'b0000};
        vecs[13] = '{8'h09, 1'b0, 2'd3, 32'h0,         32'h08, 32'h00, 32'h08, 32'h08, 4'b1011};
        vecs[14] = '{8'h09, 1'b1, 2'd3, 32'hFF,        32'h00, 32'h00, 32'h00, 32'h00, 4'b0001};
        vecs[15] = '{8'h01, 1'b0, 2'd0, 32'h0,         32'h01, 32'h01, 32'h01, 32'h01, 4'b0110};
        vecs[16] = '{8'h01, 1'b1, 2'd2, 32'hFFFFFF01,  32'h01, 32'h01, 32'h01, 32'h01, 4'b0001};

        // Reset held with in_port low: every address reads zero, no irq.
        #2 reset_n = 1'b0;
        #1;
        expectAll("reset async", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
        checkOutput();
        for (int a = 0; a < 4; a++) begin
            address = a[1:0];
            tick(1);
            expectAll($sformatf("reset addr%0d", a), 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
            checkOutput();
        end
        reset_n = 1'b1;
        address = 2'd0;
        tick(1);
        expectAll("post-reset data", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
        checkOutput();

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Same-cycle W1C and rising edge on bit0: set must win; irqA rises on the capture edge.
        in_port = 8'h00;
        address = 2'd3;
        busIdle();
        tick(S + 1);
        chipselect = 1'b1; write_n = 1'b0; writedata = 32'hFF;
        tick(1);
        busIdle();
        in_port = 8'h01;
        tick(S);
        expectVal("latency irqA before capture", 4, 32'h0);
        checkOutput();
        chipselect = 1'b1; write_n = 1'b0; writedata = 32'h01;
        tick(1);
        busIdle();
        expectVal("latency irqA at capture", 4, 32'h1);
        checkOutput();
        tick(1);
        expectAll("set-wins", 32'h01, 32'h00, 32'h01, 32'h01, 4'b1011);
        checkOutput();

        // Level irq stays up for S edges after in_port falls, drops on edge S+1.
        in_port = 8'h00;
        for (int k = 0; k < S; k++) begin
            tick(1);
            expectVal($sformatf("level irqL hold%0d", k), 7, 32'h1);
            checkOutput();
        end
        tick(1);
        expectVal("level irqL drop", 7, 32'h0);
        expectVal("falling irqF", 5, 32'h1);
        checkOutput();

        // Mid-operation reset clears everything; input held high through reset captures once.
        in_port = 8'h01;
        reset_n = 1'b0;
        #1;
        expectAll("midreset", 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000);
        checkOutput();
        tick(2);
        reset_n = 1'b1;
        tick(S + 1);
        expectVal("postreset rdA early", 0, 32'h0);
        checkOutput();
        tick(1);
        expectAll("postreset capture", 32'h01, 32'h00, 32'h01, 32'h01, 4'b0000);
        checkOutput();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
